// File: rtl/stegano_pkg.sv
// Shared definitions for the LSB steganography embedder and extractor.
// Optional feature macro used by the extractor: STEG_PARITY_EN.
package stegano_pkg;

  localparam int PAYLOAD_W     = 128;
  localparam int BITS_PER_BYTE = 2;
  localparam int BYTE_W        = 8;

  // One payload bit pair travels in each stego byte.
  localparam int BEATS = PAYLOAD_W / BITS_PER_BYTE;

  // Beat counter must hold 0..BEATS inclusive, so it never wraps.
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK,
    DONE
  } stegano_rx_state_t;

endpackage

// File: rtl/stegano_lsb_shift.sv
// Payload reassembly shift register: each shift moves the register left by
// one bit pair and inserts the new pair at the LSB end, so the first pair
// shifted in ends up in the MSBs after BEATS shifts.
module stegano_lsb_shift
  import stegano_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_shift,
  input  logic [BITS_PER_BYTE-1:0] i_bits,
  output logic [PAYLOAD_W-1:0]     o_q
);

  logic [PAYLOAD_W-1:0] r_q;

  // Clear on reset or frame start, otherwise shift in one pair per beat.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst || i_clear) begin
      r_q <= '0;
    end else if (i_shift) begin
      r_q <= {r_q[PAYLOAD_W-BITS_PER_BYTE-1:0], i_bits};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/stegano_extract.sv
// Receiver-side LSB steganography extractor: collects BEATS stego bytes,
// reassembles the secret payload from their two LSBs (MSB-first) and
// presents it once with a one-cycle payload_valid strobe.
// Optional feature macro: STEG_PARITY_EN (adds a CHECK state that accepts one
// extra beat carrying the XOR of all bit pairs and flags payload_err).
module stegano_extract
  import stegano_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 stego_valid,
  input  logic [BYTE_W-1:0]    stego_byte,
  output logic                 stego_ready,
  output logic [BYTE_W-1:0]    cover_out,
  output logic [PAYLOAD_W-1:0] payload,
  output logic                 payload_valid,
  output logic                 busy,
  output logic                 payload_err
);

  stegano_rx_state_t r_state;
  stegano_rx_state_t w_next;

  logic [CNT_W-1:0]         r_cnt;
  logic [BYTE_W-1:0]        r_cover;
  logic [PAYLOAD_W-1:0]     r_payload;
  logic [PAYLOAD_W-1:0]     w_shift_q;
  logic [PAYLOAD_W-1:0]     w_final;
  logic [BITS_PER_BYTE-1:0] w_pair;
  logic                     w_start;
  logic                     w_accept;
  logic                     w_collect_beat;
  logic                     w_last_beat;

  assign w_pair  = stego_byte[BITS_PER_BYTE-1:0];
  assign w_start = (r_state == IDLE) && en;

`ifdef STEG_PARITY_EN
  assign stego_ready = (r_state == COLLECT) || (r_state == CHECK);
`else
  assign stego_ready = (r_state == COLLECT);
`endif

  assign w_accept       = stego_valid && stego_ready;
  assign w_collect_beat = w_accept && (r_state == COLLECT);
  assign w_last_beat    = w_collect_beat && (r_cnt == CNT_W'(BEATS - 1));

  // The final pair lands in the shift register on the same edge that enters
  // DONE, so the payload register is loaded from the post-shift value.
  assign w_final = (r_state == COLLECT)
                 ? {w_shift_q[PAYLOAD_W-BITS_PER_BYTE-1:0], w_pair}
                 : w_shift_q;

  stegano_lsb_shift u_shift (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_shift (w_collect_beat),
    .i_bits  (w_pair),
    .o_q     (w_shift_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; en is only looked at in IDLE.
  always_comb begin
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred for w_next.
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (en) w_next = COLLECT;
      end
      COLLECT: begin
`ifdef STEG_PARITY_EN
        if (w_last_beat) w_next = CHECK;
`else
        if (w_last_beat) w_next = DONE;
`endif
      end
      CHECK: begin
`ifdef STEG_PARITY_EN
        if (w_accept) w_next = DONE;
`else
        w_next = IDLE;
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Beat counter, cover estimate and payload hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_cover   <= '0;
      r_payload <= '0;
    end else begin
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_collect_beat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_cover <= {stego_byte[BYTE_W-1:BITS_PER_BYTE], {BITS_PER_BYTE{1'b0}}};
      end
      if (w_next == DONE) begin
        r_payload <= w_final;
      end
    end
  end

`ifdef STEG_PARITY_EN
  logic [BITS_PER_BYTE-1:0] r_parity;
  logic                     r_err;

  // Running XOR over all pairs, compared against the extra beat in CHECK.
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_parity <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_collect_beat) begin
        r_parity <= r_parity ^ w_pair;
      end
      if ((r_state == CHECK) && w_accept) begin
        r_err <= (w_pair != r_parity);
      end
    end
  end

  assign payload_err = r_err;
`else
  assign payload_err = 1'b0;
`endif

  assign cover_out     = r_cover;
  assign payload       = r_payload;
  assign payload_valid = (r_state == DONE);
  assign busy          = (r_state == COLLECT) || (r_state == CHECK);

endmodule

// File: tb/tb_stegano_extract.sv
// Self-checking bench for stegano_extract: a table of directed frames, hand
// sequences for abort / ignored-input corners, and randomized frames checked
// against a reference model built from the payload bit-pair rules.
// Honours STEG_PARITY_EN the same way as the design.
module tb_stegano_extract;
  import stegano_pkg::*;

`ifdef STEG_PARITY_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int MAXC = 400;
  localparam logic [127:0] P_BASIC = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         stego_valid;
  logic [7:0]   stego_byte;
  logic         stego_ready;
  logic [7:0]   cover_out;
  logic [127:0] payload;
  logic         payload_valid;
  logic         busy;
  logic         payload_err;

  always #5 clk = ~clk;

  stegano_extract dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .stego_valid   (stego_valid),
    .stego_byte    (stego_byte),
    .stego_ready   (stego_ready),
    .cover_out     (cover_out),
    .payload       (payload),
    .payload_valid (payload_valid),
    .busy          (busy),
    .payload_err   (payload_err)
  );

  int checks = 0;
  int errors = 0;
  int n_pulses = 0;

  // Counts every cycle in which the valid strobe is high.
  always @(negedge clk) if (payload_valid === 1'b1) n_pulses++;

  logic [7:0] tx_bytes [0:BEATS];
  int         tx_len;
  bit         gap_mask [0:MAXC-1];

  typedef struct {
    string        name;
    logic [127:0] pl;
    logic [5:0]   upper;
    int           gap_mode;
    logic [7:0]   exp_cover;
  } vec_t;

  vec_t vecs [0:3];

  int           cyc;
  bit           gv;
  bit           bok;
  int           p0;
  logic [127:0] rp;
  logic [127:0] held;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: stego byte k carries payload bits [127-2k -: 2]; optional last
  // byte carries the XOR of all pairs (bit 0 inverted when flip_par is set).
  task automatic build_frame(input logic [127:0] pl, input bit rand_upper,
                             input logic [5:0] upper, input bit flip_par);
    logic [1:0] par;
    logic [1:0] pr;
    logic [5:0] up;
    par = 2'b00;
    for (int k = 0; k < BEATS; k++) begin
      pr = pl[127-2*k -: 2];
      up = rand_upper ? 6'($urandom) : upper;
      tx_bytes[k] = {up, pr};
      par = par ^ pr;
    end
    up = rand_upper ? 6'($urandom) : upper;
    tx_bytes[BEATS] = {up, par ^ {1'b0, flip_par}};
    tx_len = BEATS + EXTRA;
  endtask

  // mode 0: no gaps, 3: every third cycle idle, 1: random ~25% idle.
  task automatic fill_gaps(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      if (mode == 3)      gap_mask[c] = ((c % 3) == 2);
      else if (mode == 1) gap_mask[c] = ($urandom_range(0, 3) == 0);
      else                gap_mask[c] = 1'b0;
    end
  endtask

  // Expected cycles from COLLECT entry to the valid strobe.
  function automatic int model_cycles();
    int seen;
    seen = 0;
    for (int c = 0; c < MAXC; c++) begin
      if (!gap_mask[c]) seen++;
      if (seen == tx_len) return c + 1;
    end
    return -1;
  endfunction

  task automatic drive_frame(input int repulse_at, input int abort_at,
                             output int cycles, output bit got_valid, output bit busy_ok);
    int k;
    bit drv;
    bit acc;
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    k = 0;
    cycles = 0;
    got_valid = 1'b0;
    busy_ok = 1'b1;
    while (!got_valid && cycles < MAXC) begin
      if (abort_at >= 0 && k == abort_at) break;
      drv = (k < tx_len) && !gap_mask[cycles];
      stego_valid = drv;
      stego_byte  = drv ? tx_bytes[k] : 8'($urandom);
      en          = (k == repulse_at);
      if (k < tx_len && busy !== 1'b1) busy_ok = 1'b0;
      acc = drv && (stego_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) k++;
      cycles++;
      got_valid = (payload_valid === 1'b1);
    end
    stego_valid = 1'b0;
    en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stego_valid = 1'b0; stego_byte = 8'h00;
    vecs[0] = '{"basic", P_BASIC,     6'b101010, 0, 8'hA8};
    vecs[1] = '{"gaps",  P_BASIC,     6'b101010, 3, 8'hA8};
    vecs[2] = '{"ones",  {128{1'b1}}, 6'b111111, 0, 8'hFC};
    vecs[3] = '{"zeros", 128'h0,      6'b000000, 1, 8'h00};

    repeat (3) @(posedge clk);
    #1;
    check("rst_payload", payload, 0);
    check("rst_valid", payload_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", stego_ready, 0);
    check("rst_cover", cover_out, 0);
    check("rst_err", payload_err, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      build_frame(vecs[v].pl, 1'b0, vecs[v].upper, 1'b0);
      fill_gaps(vecs[v].gap_mode);
      p0 = n_pulses;
      drive_frame(-1, -1, cyc, gv, bok);
      check({vecs[v].name, "_valid_seen"}, gv, 1);
      check({vecs[v].name, "_payload"}, payload, vecs[v].pl);
      check({vecs[v].name, "_cover"}, cover_out, vecs[v].exp_cover);
      check({vecs[v].name, "_latency"}, cyc, model_cycles());
      check({vecs[v].name, "_busy_during"}, bok, 1);
      check({vecs[v].name, "_err"}, payload_err, 0);
      @(posedge clk); #1;
      check({vecs[v].name, "_valid_drop"}, payload_valid, 0);
      check({vecs[v].name, "_idle_busy"}, busy, 0);
      check({vecs[v].name, "_pulses"}, n_pulses - p0, 1);
      check({vecs[v].name, "_hold"}, payload, vecs[v].pl);
    end

    // Ignored inputs: en mid-frame, en in DONE, trailing bytes.
    build_frame(P_BASIC, 1'b0, 6'b110011, 1'b0);
    fill_gaps(0);
    p0 = n_pulses;
    drive_frame(10, -1, cyc, gv, bok);
    check("ign_latency", cyc, BEATS + EXTRA);
    check("ign_payload", payload, P_BASIC);
    for (int i = 0; i < 4; i++) begin
      en = (i == 0);
      stego_valid = 1'b1;
      stego_byte = 8'($urandom);
      check("ign_ready", stego_ready, 0);
      @(posedge clk); #1;
      en = 1'b0;
    end
    stego_valid = 1'b0;
    check("ign_busy", busy, 0);
    check("ign_payload_hold", payload, P_BASIC);
    check("ign_cover_hold", cover_out, 8'hCC);
    check("ign_pulses", n_pulses - p0, 1);

    // Reset mid-operation, then a fresh all-ones frame.
    build_frame({$urandom, $urandom, $urandom, $urandom}, 1'b1, 6'h0, 1'b0);
    fill_gaps(0);
    p0 = n_pulses;
    drive_frame(-1, 30, cyc, gv, bok);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_payload", payload, 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_pulse", n_pulses - p0, 0);
    build_frame({128{1'b1}}, 1'b0, 6'b101010, 1'b0);
    drive_frame(-1, -1, cyc, gv, bok);
    check("after_abort_valid", gv, 1);
    check("after_abort_payload", payload, {128{1'b1}});
    @(posedge clk); #1;

    // Randomized frames against the model.
    for (int r = 0; r < 6; r++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      build_frame(rp, 1'b1, 6'h0, 1'b0);
      fill_gaps(1);
      p0 = n_pulses;
      drive_frame(-1, -1, cyc, gv, bok);
      check("rand_valid", gv, 1);
      check("rand_payload", payload, rp);
      check("rand_cover", cover_out, {tx_bytes[tx_len-1][7:2], 2'b00});
      check("rand_latency", cyc, model_cycles());
      repeat (2) @(posedge clk);
      #1;
      check("rand_pulses", n_pulses - p0, 1);
    end

`ifdef STEG_PARITY_EN
    // Wrong parity beat: payload still delivered, error held until restart.
    build_frame(P_BASIC, 1'b0, 6'b101010, 1'b1);
    fill_gaps(0);
    drive_frame(-1, -1, cyc, gv, bok);
    check("par_bad_valid", gv, 1);
    check("par_bad_payload", payload, P_BASIC);
    check("par_bad_err", payload_err, 1);
    repeat (3) @(posedge clk);
    #1;
    held = payload_err;
    check("par_err_held", held, 1);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    check("par_err_cleared", payload_err, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
